// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: single-cycle ALU results win by default, buffered
// load results drain into idle cycles, with a forced drain after sustained ALU pressure.
module writeback_arbiter #(
    parameter int XLEN         = 32,
    parameter int REG_ADDR_W   = 5,
    parameter int LOAD_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                          clock,
    input  logic                          resetN,
    input  logic                          aluValid,
    output logic                          aluReady,
    input  logic [REG_ADDR_W-1:0]         aluAddress,
    input  logic [XLEN-1:0]               aluData,
    input  logic                          loadValid,
    output logic                          loadReady,
    input  logic [REG_ADDR_W-1:0]         loadAddress,
    input  logic [XLEN-1:0]               loadData,
    output logic                          registerWriteEnable,
    output logic [REG_ADDR_W-1:0]         writeAddress,
    output logic [XLEN-1:0]               writeData,
    input  logic [REG_ADDR_W-1:0]         queryAddress0,
    input  logic [REG_ADDR_W-1:0]         queryAddress1,
    output logic                          queryPending0,
    output logic                          queryPending1,
    output logic [$clog2(LOAD_DEPTH):0]   loadCount,
    output logic                          debugState
);
    localparam int PTR_W    = $clog2(LOAD_DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {
        NORMAL = 1'b0,
        DRAIN  = 1'b1
    } state_t;

    state_t                  state, state_next;
    logic [STARVE_W-1:0]     starve_cnt, starve_next;
    logic [REG_ADDR_W-1:0]   fifo_addr [LOAD_DEPTH];
    logic [XLEN-1:0]         fifo_data [LOAD_DEPTH];
    logic [PTR_W-1:0]        rd_ptr, wr_ptr;
    logic [CNT_W-1:0]        count;
    logic                    fifo_empty, push, pop, alu_win, write_sel;
    logic [REG_ADDR_W-1:0]   sel_addr;
    logic [XLEN-1:0]         sel_data;
    logic                    hit0, hit1;
    logic [PTR_W-1:0]        offset;

    // Handshake: a result transfers on a rising edge where valid && ready are both high.
    assign fifo_empty = (count == '0);
    assign loadReady  = (count < CNT_W'(LOAD_DEPTH));
    assign push       = loadValid && loadReady && (loadAddress != '0);
    assign loadCount  = count;
    assign debugState = state;

    always_comb begin
        state_next  = state;
        starve_next = starve_cnt;
        aluReady    = 1'b0;
        alu_win     = 1'b0;
        pop         = 1'b0;
        case (state)
            NORMAL: begin
                aluReady = 1'b1;
                alu_win  = aluValid && (aluAddress != '0);
                if (alu_win) begin
                    if (fifo_empty) begin
                        starve_next = '0;
                    end else if (starve_cnt == STARVE_W'(STARVE_LIMIT - 1)) begin
                        state_next  = DRAIN;
                        starve_next = '0;
                    end else begin
                        starve_next = starve_cnt + 1'b1;
                    end
                end else begin
                    pop         = !fifo_empty;
                    starve_next = '0;
                end
            end
            DRAIN: begin
                pop         = !fifo_empty;
                state_next  = NORMAL;
                starve_next = '0;
            end
            default: state_next = NORMAL;
        endcase
        write_sel = alu_win || pop;
        sel_addr  = alu_win ? aluAddress : fifo_addr[rd_ptr];
        sel_data  = alu_win ? aluData : fifo_data[rd_ptr];
    end

    // Only entries between rd_ptr and rd_ptr+count-1 (modulo depth) are live.
    always_comb begin
        hit0   = 1'b0;
        hit1   = 1'b0;
        offset = '0;
        for (int i = 0; i < LOAD_DEPTH; i++) begin
            offset = PTR_W'(i) - rd_ptr;
            if (CNT_W'(offset) < count) begin
                if (fifo_addr[i] == queryAddress0) hit0 = 1'b1;
                if (fifo_addr[i] == queryAddress1) hit1 = 1'b1;
            end
        end
        queryPending0 = (queryAddress0 != '0) &&
                        (hit0 || (registerWriteEnable && (writeAddress == queryAddress0)));
        queryPending1 = (queryAddress1 != '0) &&
                        (hit1 || (registerWriteEnable && (writeAddress == queryAddress1)));
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state               <= NORMAL;
            starve_cnt          <= '0;
            rd_ptr              <= '0;
            wr_ptr              <= '0;
            count               <= '0;
            registerWriteEnable <= 1'b0;
            writeAddress        <= '0;
            writeData           <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            registerWriteEnable <= write_sel;
            if (write_sel) begin
                writeAddress <= sel_addr;
                writeData    <= sel_data;
            end
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are meaningful.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_addr[wr_ptr] <= loadAddress;
            fifo_data[wr_ptr] <= loadData;
        end
    end
endmodule
